// File: rtl/stream_to_tiled_array_if.sv
// Stream-in / array-out bundle for stream_to_tiled_array.
// The slave modport is the converter's view; the master modport is the producer/consumer side.
interface stream_to_tiled_array_if #(
  parameter int BIT_WIDTH  = 4,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int BEAT_ELEMS = 4
);
  logic [BEAT_ELEMS*BIT_WIDTH-1:0] in_data;
  logic                            in_valid;
  logic                            in_last;
  logic                            in_ready;
  logic [ROWS*COLS*BIT_WIDTH-1:0]  out_array;
  logic                            out_valid;
  logic                            out_ready;
  logic                            frame_err;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_array, out_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_array, out_valid, frame_err
  );
endinterface

// File: rtl/stream_to_tiled_array.sv
// Gathers a ROWS x COLS frame from a beat stream into a tiled, column-major register array.
// Define DOUBLE_BUFFER_EN for two banks so the next frame can fill while one is held.
module stream_to_tiled_array #(
  parameter int BIT_WIDTH  = 4,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int SUB_ROWS   = 4,
  parameter int BEAT_ELEMS = 4
) (
  input logic                    clk,
  input logic                    rst,
  stream_to_tiled_array_if.slave bus
);
  localparam int ELEMS = ROWS * COLS;
  localparam int BEATS = ELEMS / BEAT_ELEMS;
  localparam int CW    = $clog2(BEATS + 1);
`ifdef DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_acc;
  logic          w_final;
  logic [NB-1:0] w_bank_sel;

  assign w_acc   = bus.in_valid & w_in_ready;
  assign w_final = w_acc && (r_cnt == CW'(BEATS - 1));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.frame_err = r_err;

  // Framing comes from the beat counter only; in_last is merely cross-checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_acc && (bus.in_last != (r_cnt == CW'(BEATS - 1)));
      if (w_acc)
        r_cnt <= w_final ? '0 : r_cnt + CW'(1);
    end
  end

`ifdef DOUBLE_BUFFER_EN
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_occ;
  logic       w_take;

  assign w_take      = (r_occ != 2'd0) & bus.out_ready;
  assign w_in_ready  = (r_occ < 2'd2);
  assign w_out_valid = (r_occ != 2'd0);
  assign w_bank_sel  = r_wr_ptr ? 2'b10 : 2'b01;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      r_wr_ptr <= r_wr_ptr ^ w_final;
      r_rd_ptr <= r_rd_ptr ^ w_take;
      r_occ    <= r_occ + {1'b0, w_final} - {1'b0, w_take};
    end
  end
`else
  typedef enum logic {S_FILL, S_HOLD} state_t;
  state_t r_state;
  logic   r_in_ready;
  logic   r_out_valid;

  assign w_in_ready  = r_in_ready;
  assign w_out_valid = r_out_valid;
  assign w_bank_sel  = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: if (w_final) begin
          r_state     <= S_HOLD;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b1;
        end
        S_HOLD: if (bus.out_ready) begin
          r_state     <= S_FILL;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
`endif

  // Each array cell knows at elaboration which beat and lane feeds it (inverse of the tile map).
  for (genvar gi = 0; gi < ELEMS; gi++) begin : g_elem
    localparam int R = gi / COLS;
    localparam int C = gi % COLS;
    localparam int K = (R < SUB_ROWS) ? (C * SUB_ROWS + R)
                                      : (SUB_ROWS * COLS + C * (ROWS - SUB_ROWS) + R - SUB_ROWS);
    localparam int N = K / BEAT_ELEMS;
    localparam int E = K % BEAT_ELEMS;

    logic [BIT_WIDTH-1:0] r_bank [NB];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int b = 0; b < NB; b++)
          r_bank[b] <= '0;
      end else begin
        for (int b = 0; b < NB; b++)
          if (w_acc && w_bank_sel[b] && (r_cnt == CW'(N)))
            r_bank[b] <= bus.in_data[E*BIT_WIDTH +: BIT_WIDTH];
      end
    end

`ifdef DOUBLE_BUFFER_EN
    assign bus.out_array[gi*BIT_WIDTH +: BIT_WIDTH] = r_bank[r_rd_ptr];
`else
    assign bus.out_array[gi*BIT_WIDTH +: BIT_WIDTH] = r_bank[0];
`endif
  end
endmodule
